// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: FSM encodings and strobe levels.
package regfile_mp_pkg;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic READ_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: packed write/read/reserve ports plus the ready flag.
interface regfile_mp_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2
);
    logic                              ready;
    logic [WRITE_PORTS-1:0]            write_enable;
    logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_address;
    logic [WRITE_PORTS*DATA_WIDTH-1:0] write_data;
    logic [READ_PORTS-1:0]             read_enable;
    logic [READ_PORTS*ADDR_WIDTH-1:0]  read_address;
    logic [READ_PORTS*DATA_WIDTH-1:0]  read_data;
    logic [READ_PORTS-1:0]             read_pending;
    logic                              reserve_enable;
    logic [ADDR_WIDTH-1:0]             reserve_address;

    modport master (
        input  ready, read_data, read_pending,
        output write_enable, write_address, write_data,
               read_enable, read_address, reserve_enable, reserve_address
    );

    modport slave (
        output ready, read_data, read_pending,
        input  write_enable, write_address, write_data,
               read_enable, read_address, reserve_enable, reserve_address
    );
endinterface

// File: rtl/regfile_mp_read_port.sv
// One combinational read port: gating, r0 suppression and write-to-read bypass.
module regfile_mp_read_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int WRITE_PORTS = 2
) (
    input  logic                              i_ready,
    input  logic                              i_read_enable,
    input  logic [ADDR_WIDTH-1:0]             i_read_address,
    input  logic [WRITE_PORTS-1:0]            i_write_enable,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] i_write_address,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] i_write_data,
    input  logic [DATA_WIDTH-1:0]             i_reg_data,
    input  logic                              i_reg_pending,
    output logic [DATA_WIDTH-1:0]             o_read_data,
    output logic                              o_read_pending
);

    always_comb begin
        o_read_data    = '0;
        o_read_pending = 1'b0;
        if (i_ready && i_read_enable == READ_ENABLE && i_read_address != '0) begin
            o_read_data    = i_reg_data;
            o_read_pending = i_reg_pending;
            // Ascending scan so the highest-index matching write port is the one left standing.
            for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
                if (i_write_enable[k] &&
                    i_write_address[k*ADDR_WIDTH +: ADDR_WIDTH] == i_read_address) begin
                    o_read_data    = i_write_data[k*DATA_WIDTH +: DATA_WIDTH];
                    o_read_pending = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset zeroing sweep, write bypass and
// a per-register pending scoreboard for RAW hazard detection.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 2
) (
    input logic         clock,
    input logic         reset,
    regfile_mp_if.slave bus
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_pending;
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_init_index;

    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_reg_data     [READ_PORTS];
    logic                  w_reg_pending  [READ_PORTS];
    logic [DATA_WIDTH-1:0] w_rd_data      [READ_PORTS];
    logic                  w_rd_pending   [READ_PORTS];

    assign w_ready   = (r_state == ST_RUN);
    assign bus.ready = w_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_INIT;
            r_init_index <= '0;
            r_pending    <= '0;
        end else if (r_state == ST_INIT) begin
            if (r_init_index == '1) r_state <= ST_RUN;
            else                    r_init_index <= r_init_index + 1'b1;
        end else begin
            for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
                if (bus.write_enable[k] == WRITE_ENABLE &&
                    bus.write_address[k*ADDR_WIDTH +: ADDR_WIDTH] != '0)
                    r_pending[bus.write_address[k*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
            end
            // Reserve is applied last so a newly issued producer overrides a same-edge write.
            if (bus.reserve_enable && bus.reserve_address != '0)
                r_pending[bus.reserve_address] <= 1'b1;
        end
    end

    // Storage carries no reset; the init sweep zeroes it instead.
    always_ff @(posedge clock) begin
        if (r_state == ST_INIT) begin
            r_regs[r_init_index] <= '0;
        end else begin
            for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
                if (bus.write_enable[k] == WRITE_ENABLE &&
                    bus.write_address[k*ADDR_WIDTH +: ADDR_WIDTH] != '0)
                    r_regs[bus.write_address[k*ADDR_WIDTH +: ADDR_WIDTH]] <=
                        bus.write_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar r = 0; r < READ_PORTS; r++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        assign w_addr           = bus.read_address[r*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_reg_data[r]    = r_regs[w_addr];
        assign w_reg_pending[r] = r_pending[w_addr];

        regfile_mp_read_port #(
            .DATA_WIDTH  (DATA_WIDTH),
            .ADDR_WIDTH  (ADDR_WIDTH),
            .WRITE_PORTS (WRITE_PORTS)
        ) u_port (
            .i_ready         (w_ready),
            .i_read_enable   (bus.read_enable[r]),
            .i_read_address  (w_addr),
            .i_write_enable  (bus.write_enable),
            .i_write_address (bus.write_address),
            .i_write_data    (bus.write_data),
            .i_reg_data      (w_reg_data[r]),
            .i_reg_pending   (w_reg_pending[r]),
            .o_read_data     (w_rd_data[r]),
            .o_read_pending  (w_rd_pending[r])
        );
    end

    always_comb begin
        bus.read_data    = '0;
        bus.read_pending = '0;
        for (int unsigned r = 0; r < READ_PORTS; r++) begin
            bus.read_data[r*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[r];
            bus.read_pending[r]                       = w_rd_pending[r];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized bench for regfile_mp against an array/scoreboard model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int RP    = 2;
    localparam int WP    = 2;
    localparam int DEPTH = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;

    regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .WRITE_PORTS(WP)) bus ();

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .WRITE_PORTS(WP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_regs [DEPTH];
    logic          m_pend [DEPTH];
    logic          m_ready    = 1'b0;
    int            m_init_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_read(input int r, output logic [DW-1:0] d, output logic p);
        logic [AW-1:0] a;
        a = bus.read_address[r*AW +: AW];
        d = '0;
        p = 1'b0;
        if (!m_ready || !bus.read_enable[r] || a == 0) return;
        d = m_regs[a];
        p = m_pend[a];
        for (int k = WP-1; k >= 0; k--) begin
            if (bus.write_enable[k] && bus.write_address[k*AW +: AW] == a) begin
                d = bus.write_data[k*DW +: DW];
                p = 1'b0;
                break;
            end
        end
    endfunction

    task automatic idle();
        bus.write_enable    = '0;
        bus.write_address   = '0;
        bus.write_data      = '0;
        bus.read_enable     = '0;
        bus.read_address    = '0;
        bus.reserve_enable  = 1'b0;
        bus.reserve_address = '0;
    endtask

    task automatic wr(input int k, input int a, input logic [DW-1:0] d);
        bus.write_enable[k]        = 1'b1;
        bus.write_address[k*AW +: AW] = AW'(a);
        bus.write_data[k*DW +: DW] = d;
    endtask

    task automatic rd(input int r, input int a);
        bus.read_enable[r]           = 1'b1;
        bus.read_address[r*AW +: AW] = AW'(a);
    endtask

    task automatic reserve(input int a);
        bus.reserve_enable  = 1'b1;
        bus.reserve_address = AW'(a);
    endtask

    // Check all outputs against the model, then clock once and advance the model.
    task automatic step(input string tag);
        logic [DW-1:0] d;
        logic          p;
        #1;
        check({tag, " ready"}, 64'(bus.ready), 64'(m_ready));
        for (int r = 0; r < RP; r++) begin
            exp_read(r, d, p);
            check($sformatf("%s rd%0d data", tag, r), 64'(bus.read_data[r*DW +: DW]), 64'(d));
            check($sformatf("%s rd%0d pend", tag, r), 64'(bus.read_pending[r]), 64'(p));
        end
        @(posedge clock);
        if (reset) begin
            if (!m_ready) begin
                m_init_cnt++;
                if (m_init_cnt == DEPTH) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
                end
            end else begin
                for (int k = 0; k < WP; k++) begin
                    int a;
                    a = int'(bus.write_address[k*AW +: AW]);
                    if (bus.write_enable[k] && a != 0) begin
                        m_regs[a] = bus.write_data[k*DW +: DW];
                        m_pend[a] = 1'b0;
                    end
                end
                if (bus.reserve_enable && bus.reserve_address != 0)
                    m_pend[bus.reserve_address] = 1'b1;
            end
        end
        @(negedge clock);
    endtask

    task automatic model_reset();
        m_ready    = 1'b0;
        m_init_cnt = 0;
        for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clock);
        #1;
        check("reset ready", 64'(bus.ready), 64'd0);
        check("reset pend", 64'(bus.read_pending), 64'd0);
        for (int c = 0; c < 3; c++) step("rst");

        reset = 1'b1;
        rd(0, 5);
        for (int c = 0; c < DEPTH; c++) begin
            #1;
            check("sweep r5", 64'(bus.read_data[0 +: DW]), 64'd0);
            step("sweep");
        end
        #1;
        check("ready after 32", 64'(bus.ready), 64'd1);
        check("r5 after init", 64'(bus.read_data[0 +: DW]), 64'd0);
        step("r5");

        idle(); wr(0, 3, 32'h1111_1111); wr(1, 3, 32'h2222_2222); rd(0, 3);
        #1; check("r3 bypass", 64'(bus.read_data[0 +: DW]), 64'h2222_2222);
        step("wr3");
        idle(); rd(0, 3);
        #1; check("r3 stored", 64'(bus.read_data[0 +: DW]), 64'h2222_2222);
        step("rd3");

        idle(); reserve(7); rd(0, 7);
        #1; check("r7 no rsv bypass", 64'(bus.read_pending[0]), 64'd0);
        step("rsv7");
        idle(); rd(0, 7);
        #1; check("r7 pend", 64'(bus.read_pending[0]), 64'd1);
        check("r7 stale", 64'(bus.read_data[0 +: DW]), 64'd0);
        step("rd7");
        idle(); wr(0, 7, 32'hDEAD_BEEF); rd(0, 7);
        #1; check("r7 byp pend", 64'(bus.read_pending[0]), 64'd0);
        check("r7 byp data", 64'(bus.read_data[0 +: DW]), 64'hDEAD_BEEF);
        step("wr7");
        idle(); rd(1, 7);
        #1; check("r7 cleared", 64'(bus.read_pending[1]), 64'd0);
        step("rd7b");

        idle(); reserve(9); wr(1, 9, 32'h55);
        step("rsvwr9");
        idle(); rd(1, 9);
        #1; check("r9 data", 64'(bus.read_data[DW +: DW]), 64'h55);
        check("r9 pend", 64'(bus.read_pending[1]), 64'd1);
        step("rd9");

        idle(); wr(0, 0, '1); wr(1, 0, '1); reserve(0); rd(0, 0); rd(1, 0);
        #1; check("r0 data", 64'(bus.read_data), 64'd0);
        check("r0 pend", 64'(bus.read_pending), 64'd0);
        step("wr0");
        idle(); rd(0, 0); rd(1, 0);
        #1; check("r0 after", 64'(bus.read_data), 64'd0);
        step("rd0");

        for (int c = 0; c < 400; c++) begin
            idle();
            for (int k = 0; k < WP; k++) begin
                bus.write_enable[k]           = 1'($urandom);
                bus.write_address[k*AW +: AW] = AW'($urandom_range(0, 11));
                bus.write_data[k*DW +: DW]    = $urandom;
            end
            for (int r = 0; r < RP; r++) begin
                bus.read_enable[r]           = ($urandom_range(0, 3) != 0);
                bus.read_address[r*AW +: AW] = AW'($urandom_range(0, 11));
            end
            bus.reserve_enable  = ($urandom_range(0, 2) == 0);
            bus.reserve_address = AW'($urandom_range(0, 11));
            step("rand");
        end

        idle(); wr(1, 4, 32'hABCD);
        step("wr4");
        idle(); reserve(4);
        step("rsv4");
        idle(); rd(0, 4);
        #1; check("r4 pend", 64'(bus.read_pending[0]), 64'd1);
        check("r4 data", 64'(bus.read_data[0 +: DW]), 64'hABCD);
        reset = 1'b0;
        #1; check("midrst ready", 64'(bus.ready), 64'd0);
        check("midrst pend", 64'(bus.read_pending), 64'd0);
        check("midrst data", 64'(bus.read_data), 64'd0);
        model_reset();
        step("midrst");
        reset = 1'b1;
        for (int c = 0; c < DEPTH; c++) step("resweep");
        #1; check("r4 zeroed", 64'(bus.read_data[0 +: DW]), 64'd0);
        check("r4 pend clr", 64'(bus.read_pending[0]), 64'd0);
        step("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
